// File: rtl/mt_thread_sched_if.sv
// Bundles the scheduler's core-facing control, writeback and issue signals.
// The master side is the core/fetch environment and the slave side is the scheduler.
interface mt_thread_sched_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_THREADS   = 4,
  parameter int NUM_TGRPS     = 2
);
  localparam int TID_W = $clog2(NUM_THREADS);
  localparam int TG_W  = $clog2(NUM_TGRPS);

  logic                     swap_tgrp;
  logic [NUM_THREADS-1:0]   thread_en;
  logic                     stall;
  logic                     pc_wr_en;
  logic [TID_W-1:0]         pc_wr_tid;
  logic [ADDRESS_WIDTH-1:0] pc_wr_val;
  logic                     issue_valid;
  logic [TID_W-1:0]         issue_tid;
  logic [ADDRESS_WIDTH-1:0] issue_pc;
  logic [TG_W-1:0]          tgrp;
  logic                     swap_busy;

  modport master (
    output swap_tgrp, thread_en, stall, pc_wr_en, pc_wr_tid, pc_wr_val,
    input  issue_valid, issue_tid, issue_pc, tgrp, swap_busy
  );

  modport slave (
    input  swap_tgrp, thread_en, stall, pc_wr_en, pc_wr_tid, pc_wr_val,
    output issue_valid, issue_tid, issue_pc, tgrp, swap_busy
  );
endinterface

// File: rtl/mt_thread_sched.sv
// Round-robin thread issue scheduler with a per-group PC table.
// A group swap stops issue, waits for in-flight writebacks to drain, then advances the group.
module mt_thread_sched #(
  parameter int              ADDRESS_WIDTH   = 32,
  parameter int              NUM_THREADS     = 4,
  parameter int              NUM_TGRPS       = 2,
  parameter int              PIPE_DEPTH      = 3,
  parameter longint unsigned RESET_PC_BASE   = 0,
  parameter longint unsigned RESET_PC_STRIDE = 64
) (
  input logic               clk,
  input logic               rst_n,
  mt_thread_sched_if.slave  bus
);
  localparam int TID_W = $clog2(NUM_THREADS);
  localparam int TG_W  = $clog2(NUM_TGRPS);
  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_e;

  state_e                   state_q, state_d;
  logic [TG_W-1:0]          tgrp_q, tgrp_d;
  logic [TID_W-1:0]         ptr_q, ptr_d;
  logic                     issueValid_q, issueValid_d;
  logic [TID_W-1:0]         issueTid_q, issueTid_d;
  logic [ADDRESS_WIDTH-1:0] issuePc_q, issuePc_d;
  logic [CNT_W-1:0]         drainCnt_q, drainCnt_d;
  logic                     swapBusy_q, swapBusy_d;
  logic [ADDRESS_WIDTH-1:0] pcTable_q [NUM_TGRPS][NUM_THREADS];

  logic                     selFound;
  logic [TID_W-1:0]         selTid;
  logic [TID_W-1:0]         candTid;

  function automatic logic [ADDRESS_WIDTH-1:0] resetPc(input int g, input int t);
    return ADDRESS_WIDTH'(RESET_PC_BASE + 64'(g * NUM_THREADS + t) * RESET_PC_STRIDE);
  endfunction

  // Thread counts are powers of two, so pointer arithmetic wraps for free.
  always_comb begin
    selFound = 1'b0;
    selTid   = '0;
    candTid  = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      candTid = ptr_q + TID_W'(i);
      if (!selFound && bus.thread_en[candTid]) begin
        selFound = 1'b1;
        selTid   = candTid;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tgrp_d       = tgrp_q;
    ptr_d        = ptr_q;
    issueValid_d = issueValid_q;
    issueTid_d   = issueTid_q;
    issuePc_d    = issuePc_q;
    drainCnt_d   = drainCnt_q;
    case (state_q)
      RUN: begin
        if (bus.swap_tgrp) begin
          state_d      = DRAIN;
          issueValid_d = 1'b0;
          drainCnt_d   = CNT_W'(PIPE_DEPTH);
        end else if (!bus.stall) begin
          if (selFound) begin
            issueValid_d = 1'b1;
            issueTid_d   = selTid;
            ptr_d        = selTid;
            issuePc_d    = (bus.pc_wr_en && bus.pc_wr_tid == selTid) ?
                           bus.pc_wr_val : pcTable_q[tgrp_q][selTid];
          end else begin
            issueValid_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        issueValid_d = 1'b0;
        if (!bus.stall) begin
          drainCnt_d = drainCnt_q - CNT_W'(1);
          if (drainCnt_q == CNT_W'(1)) state_d = SWAP;
        end
      end
      SWAP: begin
        issueValid_d = 1'b0;
        tgrp_d       = tgrp_q + TG_W'(1);
        ptr_d        = '1;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
    swapBusy_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      tgrp_q       <= '0;
      ptr_q        <= '1;
      issueValid_q <= 1'b0;
      issueTid_q   <= '0;
      issuePc_q    <= '0;
      drainCnt_q   <= '0;
      swapBusy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgrp_q       <= tgrp_d;
      ptr_q        <= ptr_d;
      issueValid_q <= issueValid_d;
      issueTid_q   <= issueTid_d;
      issuePc_q    <= issuePc_d;
      drainCnt_q   <= drainCnt_d;
      swapBusy_q   <= swapBusy_d;
    end
  end

  // Writebacks always target the group that is still active, even while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_TGRPS; g++)
        for (int t = 0; t < NUM_THREADS; t++)
          pcTable_q[g][t] <= resetPc(g, t);
    end else if (bus.pc_wr_en) begin
      pcTable_q[tgrp_q][bus.pc_wr_tid] <= bus.pc_wr_val;
    end
  end

  assign bus.issue_valid = issueValid_q;
  assign bus.issue_tid   = issueTid_q;
  assign bus.issue_pc    = issuePc_q;
  assign bus.tgrp        = tgrp_q;
  assign bus.swap_busy   = swapBusy_q;
endmodule

// File: doc/mt_thread_sched.md
Name: mt_thread_sched

Overview:
Thread issue scheduler that sits directly upstream of the multithreaded CPU core. It keeps a per-thread program-counter table for every thread group and picks one enabled thread of the active group each cycle, round-robin. It presents that thread's id and PC to fetch. It also executes thread-group swap requests (swap_tgrp): issue stops, in-flight PC writebacks drain, and the group then switches.

Parameters:
ADDRESS_WIDTH, 32, width of PCs
NUM_THREADS, 4, threads per group (power of two, >=2)
NUM_TGRPS, 2, number of thread groups (power of two, >=2)
PIPE_DEPTH, 3, core cycles from issue to PC writeback; sets drain length
RESET_PC_BASE, 0, reset PC of group 0 thread 0
RESET_PC_STRIDE, 64, PC spacing between consecutive threads (global index g*NUM_THREADS+t)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
swap_tgrp  in  1  group-swap request; sampled on clock edges; accepted only in RUN
thread_en  in  NUM_THREADS  per-thread enable mask for the active group
stall  in  1  core back-pressure; freezes issue and drain counting
pc_wr_en  in  1  PC writeback strobe from core
pc_wr_tid  in  log2(NUM_THREADS)  thread being written back (active group)
pc_wr_val  in  ADDRESS_WIDTH  next PC for that thread
issue_valid  out  1  issue_tid/issue_pc are valid
issue_tid  out  log2(NUM_THREADS)  issued thread id
issue_pc  out  ADDRESS_WIDTH  issued PC
tgrp  out  log2(NUM_TGRPS)  active thread group
swap_busy  out  1  high in DRAIN and SWAP

Behaviour:
- Reset (rst=0, async): state=RUN; tgrp=0; issue_valid=0; issue_tid=0; issue_pc=0; swap_busy=0; round-robin pointer=NUM_THREADS-1, so thread 0 is searched first; PC[g][t]=RESET_PC_BASE+(g*NUM_THREADS+t)*RESET_PC_STRIDE, truncated to ADDRESS_WIDTH.
- All outputs are registered. The selection made at edge N is visible after edge N.
- PC table write: at an edge with pc_wr_en=1, PC[tgrp][pc_wr_tid]<=pc_wr_val. The write is accepted in every state, including during stall.
- Bypass: if the thread selected at an edge equals pc_wr_tid and pc_wr_en=1 at that edge, issue_pc takes pc_wr_val.
- State RUN, edge with swap_tgrp=1: go to DRAIN; issue_valid<=0; drain counter<=PIPE_DEPTH. swap_tgrp has priority over stall and issue.
- State RUN, no swap, stall=1: all issue registers and the pointer hold.
- State RUN, no swap, stall=0: select the first thread with thread_en=1, searching from pointer+1 modulo NUM_THREADS. On a hit: issue_valid<=1, issue_tid<=sel, issue_pc<=PC (or bypass), pointer<=sel. If thread_en=0: issue_valid<=0, pointer holds.
- State DRAIN: issue_valid=0. The counter decrements on each edge with stall=0. When the counter is 1 and stall=0, go to SWAP. Writebacks still land in the old group.
- State SWAP (1 cycle): tgrp<=tgrp+1, wrapping NUM_TGRPS-1 to 0; pointer<=NUM_THREADS-1; go to RUN.
- swap_busy=1 throughout DRAIN+SWAP, so it is high for exactly PIPE_DEPTH+1 cycles with no stall.
- swap_tgrp is ignored in DRAIN/SWAP and is not queued. A level held high re-triggers on the first RUN edge.
- thread_en changes take effect at the next selection. No output glitches on combinational paths.
- rst deasserted mid-DRAIN/SWAP restarts from the reset state; the swap is lost.

Test Plan:
- Release rst, thread_en=4'b1111, stall=0, no writebacks -> issue (tid,pc) = (0,0),(1,64),(2,128),(3,192),(0,0) on consecutive cycles; tgrp=0.
- thread_en=4'b1010 -> tids alternate 1,3,1,3. Then set thread_en=0 -> issue_valid=0 next cycle. Re-enable 4'b0100 -> tid 2.
- pc_wr_en=1, tid=2, val=0x84 on the same edge tid 2 is selected -> issue_pc=0x84. The next tid-2 issue also shows 0x84.
- One-cycle swap_tgrp pulse in RUN -> swap_busy=1 and issue_valid=0 for 4 cycles; then tgrp=1 and the first issue is (0,256), then (1,320). A swap_tgrp pulse during DRAIN has no effect. A later swap returns tgrp to 0 and resumes the group-0 PCs as last written.
- stall=1 for 3 cycles in RUN -> issue_valid/tid/pc frozen. Stall during DRAIN extends swap_busy by 3 cycles (7 total).
- Assert rst=0 asynchronously mid-DRAIN, between edges -> outputs reset immediately. After release, tgrp=0 and issue restarts at (0,0).
